// File: rtl/led_pkg.sv
// led_pkg: shared LED pattern mode encoding and speed-select width
package led_pkg;
  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_SCAN, MODE_BLINK} mode_e;
  localparam int DIV_SEL_W = 2;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: period max(1, COUNT>>div_sel) tick generator; in clk, rst (sync active-low), div_sel, clr; out tick (registered)
module tick_prescaler
  import led_pkg::*;
#(
  parameter int COUNT = 13500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_SEL_W-1:0] div_sel,
  input  logic                 clr,
  output logic                 tick
);
  localparam int W = $clog2(COUNT + 1);
  localparam logic [W-1:0] BASE = W'(COUNT);
  logic [W-1:0] cnt, per, lim;
  logic wrap;
  always_comb begin
    per = BASE >> div_sel;
    lim = (per == '0) ? '0 : per - W'(1);
    wrap = cnt >= lim;
  end
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + W'(1);
      tick <= wrap;
    end
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern engine; in clk, rst (sync active-low), en_i, step_i, mode_i, mode_load_i, div_sel_i; out led_o, tick_o, mode_o
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int COUNT      = 13500000,
  parameter int N_LEDS     = 6,
  parameter bit ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 step_i,
  input  logic [1:0]           mode_i,
  input  logic                 mode_load_i,
  input  logic [DIV_SEL_W-1:0] div_sel_i,
  output logic [N_LEDS-1:0]    led_o,
  output logic                 tick_o,
  output logic [1:0]           mode_o
);
  mode_e mode;
  logic [N_LEDS-1:0] pattern, nxt;
  logic dir, at_end, nxt_dir, adv;
  tick_prescaler #(.COUNT(COUNT)) u_pre (
    .clk(clk),
    .rst(rst),
    .div_sel(div_sel_i),
    .clr(mode_load_i),
    .tick(tick_o)
  );
  always_comb begin
    adv = en_i ? tick_o : step_i;
    at_end = dir ? pattern[0] : pattern[N_LEDS-1];
    nxt_dir = dir ^ at_end;
    nxt = (mode == MODE_UP)    ? pattern + N_LEDS'(1) :
          (mode == MODE_DOWN)  ? pattern - N_LEDS'(1) :
          (mode == MODE_BLINK) ? ~pattern :
          (N_LEDS == 1)        ? pattern :
          nxt_dir              ? pattern >> 1 : pattern << 1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode <= MODE_UP;
      pattern <= '0;
      dir <= 1'b0;
    end else if (mode_load_i) begin
      mode <= mode_e'(mode_i);
      pattern <= (mode_e'(mode_i) == MODE_SCAN) ? N_LEDS'(1) : '0;
      dir <= 1'b0;
    end else if (adv) begin
      pattern <= nxt;
      if (mode == MODE_SCAN) dir <= nxt_dir;
    end
  end
  assign led_o = pattern ^ {N_LEDS{ACTIVE_LOW}};
  assign mode_o = mode;
endmodule
